// File: rtl/ch_readout_ctrl_if.sv
// Host and channel signal bundle for ch_readout_ctrl.
// master: the controller (drives instructions, serial clock, results).
// slave : host/channel side (drives ARM, config, STOP_REQUEST, CNT_SER, READY).
interface ch_readout_ctrl_if;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned PT_W    = 8;
    localparam int unsigned TO_W    = 16;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned FLD_W   = 10;
    localparam int unsigned TRIG_W  = 3;

    logic              ARM;
    logic [MODE_W-1:0] MODE_IN;
    logic [PT_W-1:0]   POST_TRIG;
    logic [TO_W-1:0]   TIMEOUT;
    logic              STOP_REQUEST;
    logic              CNT_SER;
    logic              READY;

    logic              INST_START;
    logic              INST_STOP;
    logic              INST_READOUT;
    logic [MODE_W-1:0] MODE;
    logic [SEL_W-1:0]  SELECT_REG;
    logic              SPI_CLK;
    logic [FLD_W-1:0]  CA;
    logic [FLD_W-1:0]  CB;
    logic [FLD_W-1:0]  CC;
    logic [FLD_W-1:0]  CD;
    logic [FLD_W-1:0]  CE;
    logic [TRIG_W-1:0] TRIG_CNT;
    logic              VALID;
    logic              TIMED_OUT;
    logic              BUSY;

    modport master (
        input  ARM, MODE_IN, POST_TRIG, TIMEOUT, STOP_REQUEST, CNT_SER, READY,
        output INST_START, INST_STOP, INST_READOUT, MODE, SELECT_REG, SPI_CLK,
               CA, CB, CC, CD, CE, TRIG_CNT, VALID, TIMED_OUT, BUSY
    );

    modport slave (
        output ARM, MODE_IN, POST_TRIG, TIMEOUT, STOP_REQUEST, CNT_SER, READY,
        input  INST_START, INST_STOP, INST_READOUT, MODE, SELECT_REG, SPI_CLK,
               CA, CB, CC, CD, CE, TRIG_CNT, VALID, TIMED_OUT, BUSY
    );
endinterface

// File: rtl/ch_readout_ctrl.sv
// Channel acquisition/readout sequencer: start pulse, trigger wait with
// blanking and timeout, post-trigger delay, stop/readout pulses, then a
// 7-byte serial shift (SPI_CLK, SELECT_REG) recovering five 10-bit counters
// and a 3-bit trigger count, held until the host acknowledges with READY.
// Ports: FCLK clock, RSTB async active-low reset, bus (master modport) with
// host config/handshake and channel instruction/serial signals.
module ch_readout_ctrl (
    input  logic              FCLK,
    input  logic              RSTB,
    ch_readout_ctrl_if.master bus
);
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned WORD_W    = 56;
    localparam int unsigned FLD_W     = 10;
    localparam int unsigned SHIFT_CYC = 224;
    localparam int unsigned BLANK_CYC = 4;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WAIT_TRIG, S_POST, S_STOP, S_RDO, S_GAP, S_SHIFT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [1:0]          sync_q;
    logic [WORD_W-1:0]   sreg_q, sreg_d;

    logic                inst_start_q, inst_start_d;
    logic                inst_stop_q, inst_stop_d;
    logic                inst_readout_q, inst_readout_d;
    logic [1:0]          mode_q, mode_d;
    logic [2:0]          select_q, select_d;
    logic                spi_clk_q, spi_clk_d;
    logic [FLD_W-1:0]    ca_q, ca_d, cb_q, cb_d, cc_q, cc_d, cd_q, cd_d, ce_q, ce_d;
    logic [2:0]          trig_q, trig_d;
    logic                valid_q, valid_d;
    logic                timed_out_q, timed_out_d;
    logic                busy_q, busy_d;

    // STOP_REQUEST synchronizer
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) sync_q <= '0;
        else       sync_q <= {sync_q[0], bus.STOP_REQUEST};
    end

    // State, counters and registered outputs
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            sreg_q         <= '0;
            inst_start_q   <= 1'b0;
            inst_stop_q    <= 1'b0;
            inst_readout_q <= 1'b0;
            mode_q         <= '0;
            select_q       <= '0;
            spi_clk_q      <= 1'b0;
            ca_q           <= '0;
            cb_q           <= '0;
            cc_q           <= '0;
            cd_q           <= '0;
            ce_q           <= '0;
            trig_q         <= '0;
            valid_q        <= 1'b0;
            timed_out_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sreg_q         <= sreg_d;
            inst_start_q   <= inst_start_d;
            inst_stop_q    <= inst_stop_d;
            inst_readout_q <= inst_readout_d;
            mode_q         <= mode_d;
            select_q       <= select_d;
            spi_clk_q      <= spi_clk_d;
            ca_q           <= ca_d;
            cb_q           <= cb_d;
            cc_q           <= cc_d;
            cd_q           <= cd_d;
            ce_q           <= ce_d;
            trig_q         <= trig_d;
            valid_q        <= valid_d;
            timed_out_q    <= timed_out_d;
            busy_q         <= busy_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next state and next output values
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sreg_d         = sreg_q;
        inst_start_d   = 1'b0;
        inst_stop_d    = 1'b0;
        inst_readout_d = 1'b0;
        mode_d         = mode_q;
        select_d       = select_q;
        spi_clk_d      = spi_clk_q;
        ca_d           = ca_q;
        cb_d           = cb_q;
        cc_d           = cc_q;
        cd_d           = cd_q;
        ce_d           = ce_q;
        trig_d         = trig_q;
        valid_d        = valid_q;
        timed_out_d    = timed_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ARM) begin
                    state_d      = S_START;
                    cnt_d        = '0;
                    mode_d       = bus.MODE_IN;
                    timed_out_d  = 1'b0;
                    inst_start_d = 1'b1;
                end
            end
            S_START: begin
                inst_start_d = 1'b1;
                cnt_d        = cnt_inc;
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = S_WAIT_TRIG;
                    cnt_d        = '0;
                    inst_start_d = 1'b0;
                end
            end
            S_WAIT_TRIG: begin
                // Saturate so a TIMEOUT=0 wait never re-enters the blanking window
                cnt_d = (&cnt_q) ? cnt_q : cnt_inc;
                // Trigger is checked first so it wins over a same-cycle timeout
                if (sync_q[1] && (cnt_q >= CNT_W'(BLANK_CYC))) begin
                    state_d = S_POST;
                    cnt_d   = '0;
                end else if ((bus.TIMEOUT != '0) &&
                             ((17'(cnt_q) + 17'd1) == 17'(bus.TIMEOUT))) begin
                    state_d     = S_STOP;
                    cnt_d       = '0;
                    timed_out_d = 1'b1;
                    inst_stop_d = 1'b1;
                end
            end
            S_POST: begin
                cnt_d = cnt_inc;
                // POST_TRIG=0 degenerates to a single POST cycle
                if (cnt_inc >= CNT_W'(bus.POST_TRIG)) begin
                    state_d     = S_STOP;
                    cnt_d       = '0;
                    inst_stop_d = 1'b1;
                end
            end
            S_STOP: begin
                inst_stop_d = 1'b1;
                cnt_d       = cnt_inc;
                if (cnt_q == CNT_W'(1)) begin
                    state_d        = S_RDO;
                    cnt_d          = '0;
                    inst_stop_d    = 1'b0;
                    inst_readout_d = 1'b1;
                end
            end
            S_RDO: begin
                inst_readout_d = 1'b1;
                cnt_d          = cnt_inc;
                if (cnt_q == CNT_W'(1)) begin
                    state_d        = S_GAP;
                    cnt_d          = '0;
                    inst_readout_d = 1'b0;
                end
            end
            S_GAP: begin
                state_d   = S_SHIFT;
                cnt_d     = '0;
                select_d  = 3'd0;
                spi_clk_d = 1'b0;
            end
            S_SHIFT: begin
                // Each bit: 2 cycles low then 2 high; the falling edge captures
                // and also opens the next bit, so bytes start with SPI_CLK low.
                cnt_d = cnt_inc;
                if (cnt_inc[1:0] == 2'd2) spi_clk_d = 1'b1;
                if (cnt_inc[1:0] == 2'd0) begin
                    spi_clk_d = 1'b0;
                    sreg_d    = {sreg_q[WORD_W-2:0], bus.CNT_SER};
                end
                if (cnt_inc[4:0] == 5'd0) select_d = cnt_inc[7:5];
                if (cnt_inc == CNT_W'(SHIFT_CYC)) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    select_d = select_q;
                    valid_d  = 1'b1;
                    trig_d   = sreg_d[52:50];
                    ce_d     = sreg_d[49:40];
                    cd_d     = sreg_d[39:30];
                    cc_d     = sreg_d[29:20];
                    cb_d     = sreg_d[19:10];
                    ca_d     = sreg_d[9:0];
                end
            end
            S_DONE: begin
                if (bus.READY) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.INST_START   = inst_start_q;
    assign bus.INST_STOP    = inst_stop_q;
    assign bus.INST_READOUT = inst_readout_q;
    assign bus.MODE         = mode_q;
    assign bus.SELECT_REG   = select_q;
    assign bus.SPI_CLK      = spi_clk_q;
    assign bus.CA           = ca_q;
    assign bus.CB           = cb_q;
    assign bus.CC           = cc_q;
    assign bus.CD           = cd_q;
    assign bus.CE           = ce_q;
    assign bus.TRIG_CNT     = trig_q;
    assign bus.VALID        = valid_q;
    assign bus.TIMED_OUT    = timed_out_q;
    assign bus.BUSY         = busy_q;
endmodule
